// File: rtl/fp_decode_pkg.sv
// Shared constants and helpers for the FP operand decoder.
// Optional subnormal normalisation is enabled by FP_DECODE_NORM_EN.
package fp_decode_pkg;

  localparam int CLS_ZERO = 0;
  localparam int CLS_SUB  = 1;
  localparam int CLS_NORM = 2;
  localparam int CLS_INF  = 3;
  localparam int CLS_NAN  = 4;
  localparam int CLS_W    = 5;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Leading-zero count of a left-justified 64-bit value; 64 when all zero.
  function automatic int lzc64(input logic [63:0] v);
    int  n;
    bit  found;
    n     = 64;
    found = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 63 - i;
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_field_decode.sv
// Combinational classify/unpack of one IEEE-754 operand.
// FP_DECODE_NORM_EN: subnormals are left-normalised with adjusted exponent.
module fp_field_decode
  import fp_decode_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic [EXP_W+MAN_W:0] op_i,
  output logic                 sign_o,
  output logic [EXP_W+1:0]     exp_o,
  output logic [MAN_W:0]       mant_o,
  output logic [CLS_W-1:0]     cls_o
);

  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] BIAS_X = XW'(bias_of(EXP_W));

  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] f;
  logic             e_zero;
  logic             e_ones;
  logic             f_zero;

  assign e      = op_i[EXP_W+MAN_W-1:MAN_W];
  assign f      = op_i[MAN_W-1:0];
  assign e_zero = ~|e;
  assign e_ones = &e;
  assign f_zero = ~|f;

`ifdef FP_DECODE_NORM_EN
  logic [6:0] lz;
  assign lz = 7'(lzc64({f, {(64-MAN_W){1'b0}}}));
`endif

  always_comb begin
    sign_o = op_i[EXP_W+MAN_W];
    exp_o  = '0;
    mant_o = '0;
    cls_o  = '0;
    if (e_zero) begin
      exp_o = XW'(1) - BIAS_X;
      if (f_zero) begin
        cls_o[CLS_ZERO] = 1'b1;
      end else begin
        cls_o[CLS_SUB] = 1'b1;
`ifdef FP_DECODE_NORM_EN
        // 1-bias-(L+1) simplifies to -bias-L
        mant_o = {1'b0, f} << (lz + 7'd1);
        exp_o  = '0 - BIAS_X - XW'(lz);
`else
        mant_o = {1'b0, f};
`endif
      end
    end else if (e_ones) begin
      exp_o  = BIAS_X + XW'(1);
      mant_o = {1'b1, f};
      if (f_zero) cls_o[CLS_INF] = 1'b1;
      else        cls_o[CLS_NAN] = 1'b1;
    end else begin
      exp_o           = XW'(e) - BIAS_X;
      mant_o          = {1'b1, f};
      cls_o[CLS_NORM] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_decode_pipe.sv
// Two-operand FP decoder: output register plus one skid entry, registered IN_READY.
// FP_DECODE_NORM_EN selects normalised subnormal output in fp_field_decode.
module fp_decode_pipe
  import fp_decode_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [EXP_W+MAN_W:0] OP_A,
  input  logic [EXP_W+MAN_W:0] OP_B,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic                 SIGN_A,
  output logic                 SIGN_B,
  output logic [EXP_W+1:0]     EXP_A,
  output logic [EXP_W+1:0]     EXP_B,
  output logic [MAN_W:0]       MANT_A,
  output logic [MAN_W:0]       MANT_B,
  output logic [CLS_W-1:0]     CLASS_A,
  output logic [CLS_W-1:0]     CLASS_B
);

  localparam int DW = 1 + (EXP_W + 2) + (MAN_W + 1) + CLS_W;

  logic                 sign_a, sign_b;
  logic [EXP_W+1:0]     exp_a, exp_b;
  logic [MAN_W:0]       mant_a, mant_b;
  logic [CLS_W-1:0]     cls_a, cls_b;
  logic [2*DW-1:0]      dec_pair;

  logic [2*DW-1:0]      out_q, out_d;
  logic [2*DW-1:0]      skid_q, skid_d;
  logic                 out_valid_q, out_valid_d;
  logic                 skid_valid_q, skid_valid_d;
  logic                 in_fire;
  logic                 out_free;

  fp_field_decode #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_dec_a (
    .op_i(OP_A), .sign_o(sign_a), .exp_o(exp_a), .mant_o(mant_a), .cls_o(cls_a)
  );

  fp_field_decode #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_dec_b (
    .op_i(OP_B), .sign_o(sign_b), .exp_o(exp_b), .mant_o(mant_b), .cls_o(cls_b)
  );

  assign dec_pair = {sign_a, exp_a, mant_a, cls_a, sign_b, exp_b, mant_b, cls_b};

  assign in_fire  = IN_VALID & ~skid_valid_q;
  assign out_free = ~out_valid_q | OUT_READY;

  // Skid is only ever full while the output register is full, so it drains first.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d       = dec_pair;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec_pair;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign IN_READY  = ~skid_valid_q;
  assign OUT_VALID = out_valid_q;
  assign {SIGN_A, EXP_A, MANT_A, CLASS_A, SIGN_B, EXP_B, MANT_B, CLASS_B} = out_q;

endmodule

// File: doc/fp_decode_pipe.md
Name: fp_decode_pipe

Overview:
- Parametrised, pipelined IEEE-754 operand decoder for two operands (A, B). Next generation of the half-precision field splitter.
- Handles any EXP_W/MAN_W format and classifies each operand as zero, subnormal, normal, infinity or NaN.
- Outputs the unbiased exponent and the significand with the hidden bit restored.
- Sits at the front of the FP add/mul datapaths. Uses a valid/ready handshake with a 2-entry skid buffer so upstream never sees a combinational ready path.

Parameters:
- EXP_W, 5, exponent field width. Format width FW = 1+EXP_W+MAN_W.
- MAN_W, 10, fraction field width. Bias = 2^(EXP_W-1)-1.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- IN_VALID  in  1  operand pair valid.
- IN_READY  out  1  decoder can accept a pair.
- OP_A, OP_B  in  FW  packed operands.
- OUT_VALID  out  1  decoded pair valid.
- OUT_READY  in  1  downstream accepts.
- SIGN_A, SIGN_B  out  1  sign bit.
- EXP_A, EXP_B  out  EXP_W+2  unbiased exponent, two's complement.
- MANT_A, MANT_B  out  MAN_W+1  significand, hidden bit in MSB.
- CLASS_A, CLASS_B  out  5  one-hot {NAN,INF,NORM,SUB,ZERO}.

Behaviour:
- Reset (asynchronous, active-high):
  - OUT_VALID=0; all data outputs 0.
  - Skid entry empty, so IN_READY=1 during and after reset.
  - Reset mid-transfer discards both stages; no output appears.
- Classification, per operand (e = exponent field, f = fraction field):
  - e=0, f=0 → ZERO; EXP = 1-bias; MANT=0.
  - e=0, f≠0 → SUB; EXP = 1-bias; MANT = {0,f}.
  - 0<e<all-ones → NORM; EXP = e-bias (sign-extended); MANT = {1,f}.
  - e=all-ones, f=0 → INF; EXP = bias+1; MANT = {1,0}.
  - e=all-ones, f≠0 → NAN; EXP = bias+1; MANT = {1,f}; payload preserved.
  - Exactly one CLASS bit is set whenever OUT_VALID=1.
- Pipeline:
  - Decode is combinational into an output register; latency 1 cycle from accepted input to OUT_VALID.
  - Output register plus one skid entry; in-order delivery.
- Handshake:
  - Input transfer when IN_VALID & IN_READY. Output transfer when OUT_VALID & OUT_READY.
  - IN_READY is registered: IN_READY = skid empty.
  - Output register empty or draining: new data goes to the output register. Output register full and stalled: new data goes to the skid entry, IN_READY falls next cycle.
  - Output drains while skid full: skid moves to output, IN_READY rises next cycle.
  - Simultaneous input and output transfer with an empty skid: output register reloads and OUT_VALID stays 1.
  - OUT_VALID never drops without a transfer.
  - Output data stays stable while OUT_VALID & !OUT_READY.
- Throughput: 1 pair/cycle when OUT_READY=1.
- IN_VALID=0: no state change besides draining.

Optional Feature:
- Macro FP_DECODE_NORM_EN.
- Defined:
  - SUB operands are normalised: leading-zero count L of f (L from 0 to MAN_W-1).
  - MANT = f << (L+1), so MSB=1.
  - EXP = 1-bias-(L+1).
  - CLASS stays SUB.
  - Latency unchanged (LZC is combinational in the decode stage).
- Undefined: subnormal output as in Behaviour.
- EXP_W+2 bits covers both cases.

Decomposition:
- Package fp_decode_pkg:
  - class bit indices CLS_ZERO=0, CLS_SUB=1, CLS_NORM=2, CLS_INF=3, CLS_NAN=4;
  - function for bias from EXP_W;
  - LZC function.
- Sub-module fp_field_decode: combinational, one operand, instantiated twice.
- The top holds the skid/output registers and handshake.

Test Plan:
- fp16, OP_A=0x3C00, OP_B=0xC000, OUT_READY=1 → one cycle later: SIGN_A=0, EXP_A=0, MANT_A=0x400, CLASS_A=NORM; SIGN_B=1, EXP_B=1, MANT_B=0x400.
- OP_A=0x0001 → CLASS_A=SUB. Without macro: EXP_A=-14, MANT_A=0x001. With FP_DECODE_NORM_EN: EXP_A=-24, MANT_A=0x400.
- OP_A=0x7C00, OP_B=0xFE00 → CLASS_A=INF, EXP_A=16; CLASS_B=NAN, SIGN_B=1, MANT_B=0x600. OP_A=0x8000 → ZERO, SIGN_A=1.
- Backpressure: stream 4 pairs with OUT_READY=0 for 3 cycles → 2 accepted, then IN_READY=0. On release, all 4 emerge in order, no duplicates; data held stable while stalled.
- Assert RST for 1 cycle with both stages full → OUT_VALID=0 immediately, IN_READY=1, no stale output afterwards.
- EXP_W=8, MAN_W=23, OP_A=0x3F800000 → EXP_A=0, MANT_A=0x800000, CLASS_A=NORM. OP_A=0x7FC00000 → NAN.
